// File: rtl/boot_pkg.sv
`default_nettype none
// ============================================================================
// boot_pkg : shared FSM state type and frame byte constants for the boot loader
// Rev 1.0
// ============================================================================
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    RESP   = 3'd5,
    RUN    = 3'd6
  } state_t;

  localparam logic [7:0] MAGIC = 8'hA5;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

endpackage
`default_nettype wire

// File: rtl/boot_timeout.sv
`default_nettype none
// ============================================================================
// boot_timeout : counts idle cycles since the last received byte of a frame
// Rev 1.0
// ============================================================================
module boot_timeout #(
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int unsigned c_CW = $clog2(TIMEOUT + 1);

  logic [c_CW-1:0] r_cnt;

  // Fires in the TIMEOUT-th cycle after the last restart; counter parks there.
  assign expired = enable && (r_cnt == c_CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset || restart || !enable) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// boot_loader_ctrl : UART frame receiver that loads instruction memory and
//                    releases the core from reset after a good checksum
// Rev 1.0
// ============================================================================
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              error
);

  localparam logic [63:0] c_DEPTH = 64'd1 << ADDR_W;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [15:0]       r_word_idx;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_bytes;
  logic [7:0]        r_csum;
  logic              r_ovf;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic              r_error;

  logic              w_expired;
  logic              w_tmo_en;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_word_addr;

  assign w_tmo_en    = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                       (r_state == DATA)   || (r_state == CSUM);
  assign w_in_range  = {48'd0, r_word_idx} < c_DEPTH;
  assign w_word_addr = ADDR_W'(r_word_idx);

  boot_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .restart (rx_valid),
    .enable  (w_tmo_en),
    .expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_bytes      <= '0;
      r_csum       <= '0;
      r_ovf        <= 1'b0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_error      <= 1'b0;
    end else begin
      r_imem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_valid && rx_data == MAGIC) begin
            r_state    <= LEN_LO;
            r_error    <= 1'b0;
            r_csum     <= '0;
            r_ovf      <= 1'b0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
          end
        end
        LEN_LO: begin
          if (w_expired) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            r_len[7:0] <= rx_data;
            r_state    <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (w_expired) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            r_len[15:8] <= rx_data;
            r_state     <= ({rx_data, r_len[7:0]} == 16'd0) ? CSUM : DATA;
          end
        end
        DATA: begin
          if (w_expired) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            r_csum     <= r_csum + rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              // Words past the end of memory are summed but never written.
              if (w_in_range) begin
                r_imem_we    <= 1'b1;
                r_imem_addr  <= w_word_addr;
                r_imem_wdata <= {rx_data, r_bytes};
              end else begin
                r_ovf <= 1'b1;
              end
              r_word_idx <= r_word_idx + 16'd1;
              if (r_word_idx + 16'd1 == r_len) begin
                r_state <= CSUM;
              end
            end else begin
              r_bytes[8*r_byte_idx +: 8] <= rx_data;
            end
          end
        end
        CSUM: begin
          if (w_expired) begin
            r_state <= IDLE;
            r_error <= 1'b1;
          end else if (rx_valid) begin
            r_state    <= RESP;
            r_tx_valid <= 1'b1;
            r_tx_data  <= (rx_data == r_csum && !r_ovf) ? ACK : NAK;
          end
        end
        RESP: begin
          if (tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            if (r_tx_data == ACK) begin
              r_state <= RUN;
              r_error <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_error <= 1'b1;
            end
          end
        end
        RUN: begin
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_valid   = r_tx_valid;
  assign tx_data    = r_tx_data;
  assign imem_we    = r_imem_we;
  assign imem_addr  = r_imem_addr;
  assign imem_wdata = r_imem_wdata;
  assign error      = r_error;
  assign busy       = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA) ||
                      (r_state == CSUM)   || (r_state == RESP);
  assign cpu_reset  = (r_state != RUN);

endmodule
`default_nettype wire

// File: tb/tb_boot_loader_ctrl.sv
`default_nettype none
// ============================================================================
// tb_boot_loader_ctrl : directed frames checked against a byte-queue frame model
// Rev 1.0
// ============================================================================
module tb_boot_loader_ctrl;

  localparam int AW    = 3;
  localparam int TMO   = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_ready = 1'b1;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          error;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  boot_loader_ctrl #(
    .ADDR_W  (AW),
    .TIMEOUT (TMO)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Frame model: collects the bytes after MAGIC and derives everything from
  // the byte count, the declared word count and the running gap length.
  bit            m_in, m_resp, m_run, m_err;
  int            m_gap;
  logic [7:0]    fq[$];
  bit            e_txv, e_we;
  logic [7:0]    e_txd;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdata;

  task automatic model_byte();
    int n, nw, d, w, sum;
    n = fq.size();
    if (n < 2) return;
    nw = int'(fq[0]) + 256 * int'(fq[1]);
    d  = n - 2;
    if (d >= 1 && d <= 4 * nw) begin
      if (d % 4 == 0) begin
        w = d / 4 - 1;
        if (w < DEPTH) begin
          e_we    = 1'b1;
          e_addr  = AW'(w);
          e_wdata = {fq[n-1], fq[n-2], fq[n-3], fq[n-4]};
        end
      end
    end else if (d == 4 * nw + 1) begin
      sum = 0;
      for (int i = 2; i < n - 1; i++) sum += int'(fq[i]);
      e_txd  = ((sum % 256) == int'(fq[n-1]) && nw <= DEPTH) ? 8'h06 : 8'h15;
      e_txv  = 1'b1;
      m_resp = 1'b1;
      m_in   = 1'b0;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_in = 0; m_resp = 0; m_run = 0; m_err = 0; m_gap = 0;
      e_txv = 0; e_txd = 8'h00; e_we = 0; e_addr = '0; e_wdata = '0;
      fq.delete();
    end else begin
      e_we = 1'b0;
      if (m_resp) begin
        if (tx_ready) begin
          m_resp = 1'b0;
          if (e_txd == 8'h06) begin
            m_run = 1'b1;
            m_err = 1'b0;
          end else begin
            m_err = 1'b1;
          end
          e_txv = 1'b0;
          e_txd = 8'h00;
        end
      end else if (m_run) begin
        m_gap = 0;
      end else if (m_in) begin
        m_gap++;
        if (m_gap >= TMO) begin
          m_in  = 1'b0;
          m_err = 1'b1;
        end else if (rx_valid) begin
          m_gap = 0;
          fq.push_back(rx_data);
          model_byte();
        end
      end else if (rx_valid && rx_data == 8'hA5) begin
        m_in  = 1'b1;
        m_gap = 0;
        m_err = 1'b0;
        fq.delete();
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      chk("busy",       busy,       m_in || m_resp);
      chk("cpu_reset",  cpu_reset,  !m_run);
      chk("error",      error,      m_err);
      chk("tx_valid",   tx_valid,   e_txv);
      chk("tx_data",    tx_data,    e_txd);
      chk("imem_we",    imem_we,    e_we);
      chk("imem_addr",  imem_addr,  e_addr);
      chk("imem_wdata", imem_wdata, e_wdata);
    end
  end

  // Observed traffic, used only for the literal expectations below.
  int          tx_cnt = 0;
  int          wr_cnt = 0;
  logic [7:0]  last_tx = 8'h00;
  logic [31:0] mem [0:DEPTH-1];

  initial forever begin
    @(posedge clk);
    if (!reset && tx_valid && tx_ready) begin
      last_tx = tx_data;
      tx_cnt++;
    end
    if (!reset && imem_we) begin
      mem[imem_addr] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) send_byte(q[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tx_cnt = 0;
    wr_cnt = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_BEEF;
  endtask

  task automatic wait_not_busy(input string nm);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(n < 200), 32'd1);
  endtask

  logic [7:0] fr_ok[$]  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
  logic [7:0] fr_bad[$] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
  logic [7:0] fr_ovf[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    do_reset();
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);

    // Good frame preceded by noise in IDLE
    send_byte(8'h00);
    send_byte(8'h5A);
    send_bytes(fr_ok);
    wait_not_busy("ack");
    @(negedge clk);
    chk("ack_writes", wr_cnt, 2);
    chk("ack_mem0", mem[0], 32'h0000_0013);
    chk("ack_mem1", mem[1], 32'h0010_0093);
    chk("ack_tx", last_tx, 8'h06);
    chk("ack_cpu_reset", cpu_reset, 1'b0);
    chk("ack_error", error, 1'b0);
    send_bytes(fr_ok);
    chk("run_ignores_rx", wr_cnt, 2);

    // Bad checksum, then a recovering good frame
    do_reset();
    send_bytes(fr_bad);
    wait_not_busy("nak");
    @(negedge clk);
    chk("nak_writes", wr_cnt, 2);
    chk("nak_tx", last_tx, 8'h15);
    chk("nak_cpu_reset", cpu_reset, 1'b1);
    chk("nak_error", error, 1'b1);
    send_bytes(fr_ok);
    wait_not_busy("recover");
    @(negedge clk);
    chk("recover_tx", last_tx, 8'h06);
    chk("recover_error", error, 1'b0);

    // Empty frame
    do_reset();
    send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
    wait_not_busy("empty");
    @(negedge clk);
    chk("empty_writes", wr_cnt, 0);
    chk("empty_tx", last_tx, 8'h06);
    chk("empty_run", cpu_reset, 1'b0);

    // Inter-byte timeout, then stray bytes ignored
    do_reset();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13});
    repeat (20) @(negedge clk);
    chk("tmo_error", error, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    chk("tmo_tx", tx_cnt, 0);
    send_bytes('{8'h13, 8'h00});
    chk("tmo_stray_busy", busy, 1'b0);

    // Byte arriving in the exact timeout cycle loses
    do_reset();
    send_byte(8'hA5);
    repeat (TMO - 2) @(negedge clk);
    send_byte(8'h05);
    chk("tmo_race_busy", busy, 1'b0);
    chk("tmo_race_error", error, 1'b1);

    // Back-pressure in RESP with an injected rx byte
    do_reset();
    fr_ovf = fr_ok;
    fr_ovf.pop_back();
    send_bytes(fr_ovf);
    @(negedge clk);
    tx_ready = 1'b0;
    send_byte(8'hB6);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", tx_valid, 1'b1);
      chk("hold_data", tx_data, 8'h06);
      if (i == 4) begin
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("hold_done_tx", tx_cnt, 1);
    chk("hold_done_run", cpu_reset, 1'b0);

    // Reset in the middle of the second word
    do_reset();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_cpu_reset", cpu_reset, 1'b1);
    chk("mid_rst_we", imem_we, 1'b0);
    chk("mid_rst_addr", imem_addr, '0);
    chk("mid_rst_wdata", imem_wdata, 32'h0);
    reset = 1'b0;
    chk("mid_rst_writes", wr_cnt, 1);
    send_bytes(fr_ok);
    wait_not_busy("after_rst");
    @(negedge clk);
    chk("after_rst_tx", last_tx, 8'h06);
    chk("after_rst_writes", wr_cnt, 3);

    // Word count beyond memory depth: last word summed but not written
    do_reset();
    fr_ovf = '{8'hA5, 8'(DEPTH + 1), 8'h00};
    for (int w = 0; w <= DEPTH; w++) begin
      fr_ovf.push_back(8'(w + 1));
      fr_ovf.push_back(8'h00);
      fr_ovf.push_back(8'h00);
      fr_ovf.push_back(8'h00);
    end
    fr_ovf.push_back(8'h2D);
    send_bytes(fr_ovf);
    wait_not_busy("ovf");
    @(negedge clk);
    chk("ovf_writes", wr_cnt, DEPTH);
    chk("ovf_last_mem", mem[DEPTH-1], 32'(DEPTH));
    chk("ovf_tx", last_tx, 8'h15);
    chk("ovf_error", error, 1'b1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/boot_loader_ctrl.md
BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- ADDR_W, 12, instruction-memory word-address width (depth = 2^ADDR_W words).
- TIMEOUT, 2_000_000, maximum clock cycles allowed between received bytes inside a frame.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received UART byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  UART TX can accept a byte.
- tx_valid  out  1  response byte valid.
- tx_data  out  8  response byte.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  word to write.
- cpu_reset  out  1  holds the RV32I core in reset while high.
- busy  out  1  frame reception in progress.
- error  out  1  sticky: last frame failed.

REQ-003 The block SHALL have one clock; reset is synchronous and active-high (ports named clock and reset).

Function
REQ-004 Frame format SHALL be: MAGIC 0xA5, LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes (little-endian per word), then CSUM.

REQ-005 The FSM SHALL have the states IDLE, LEN_LO, LEN_HI, DATA, CSUM, RESP and RUN.
- Exit from IDLE occurs only on an rx byte equal to 0xA5.
- Every other byte received in IDLE is ignored.

REQ-006 Each accepted byte SHALL advance the state or byte counter exactly once, in the cycle rx_valid is high.

REQ-007 In DATA, the fourth byte of each word SHALL cause the write on the next cycle:
- imem_we is high for exactly one cycle, the cycle after that byte.
- imem_addr equals the word index, starting at 0.
- imem_wdata equals {b3,b2,b1,b0}.

REQ-008 The checksum SHALL be the 8-bit modulo-256 sum of all data bytes. LEN and MAGIC bytes are excluded.

REQ-009 N = 0 SHALL go directly from LEN_HI to CSUM, with an expected checksum of 0x00.

REQ-010 If N > 2^ADDR_W, words with index ≥ 2^ADDR_W SHALL:
- not be written, so imem_address does not wrap;
- still be summed;
- cause the frame to be answered with NAK regardless of the checksum.

REQ-011 On entering RESP, the block SHALL drive tx_data and tx_valid:
- tx_data = 0x06 (ACK) on a checksum match, otherwise 0x15 (NAK).
- tx_valid and tx_data are held stable until the cycle in which tx_valid && tx_ready is true.

REQ-012 After the handshake completes, the next state SHALL be:
- ACK: RUN. cpu_reset falls the cycle after the handshake and error clears.
- NAK: IDLE. error is set.

REQ-013 In RUN, all rx bytes SHALL be ignored. Only reset leaves RUN.

REQ-014 Inter-byte timeout SHALL apply in LEN_LO, LEN_HI, DATA and CSUM:
- The counter restarts on each rx_valid.
- On reaching TIMEOUT without a byte, the FSM goes to IDLE, error is set and no tx byte is sent.

REQ-015 error SHALL clear on acceptance of a new MAGIC byte in IDLE.

REQ-016 busy SHALL be high in the states LEN_LO through RESP inclusive, and low otherwise.

REQ-017 cpu_reset SHALL be high in every state except RUN.

REQ-018 An rx_valid arriving while in RESP SHALL be ignored.

REQ-019 An rx_valid arriving in the same cycle a timeout fires SHALL be ignored; the timeout wins.

Reset
REQ-020 Reset SHALL force the following regardless of current state, including mid-frame or mid-RESP:
- state IDLE, cpu_reset 1;
- imem_we 0, imem_addr 0, imem_wdata 0;
- tx_valid 0, tx_data 0x00;
- busy 0, error 0;
- checksum, byte counter and timeout counter cleared.

REQ-021 A frame interrupted by reset SHALL NOT be resumed. Words already written remain in memory.

Structure
REQ-022 The shared package boot_pkg SHALL hold:
- the state enum;
- the constants MAGIC=0xA5, ACK=0x06 and NAK=0x15.

REQ-023 The timeout counter SHALL be a sub-module, boot_timeout. Its ports are clock, reset, restart, enable and expired, and it is parameterised by TIMEOUT.

REQ-024 The top-level integration SHALL connect the UART RX/TX byte interfaces and the IMEM write port to this block, and drive the core reset from cpu_reset.

Verification
REQ-025 Frame A5 02 00 | 13 00 00 00 | 93 00 10 00 | CS=0xB6 with tx_ready=1 SHALL produce:
- writes addr0=0x00000013 and addr1=0x00100093, each as a single-cycle imem_we;
- tx byte 0x06;
- cpu_reset low after the handshake and error=0.

REQ-026 The same frame with CS=0x00 SHALL produce:
- both writes performed;
- tx 0x15;
- cpu_reset remaining high and error=1;
- a following valid frame then yielding ACK and clearing error.

REQ-027 Frame A5 00 00 00 SHALL produce no writes, tx 0x06 and RUN.

REQ-028 With TIMEOUT=16, A5 02 00 13 followed by 20 idle cycles SHALL produce:
- a return to IDLE with error=1 and no tx_valid;
- bytes 13 00 sent afterwards being ignored.

REQ-029 With tx_ready held low for 10 cycles in RESP:
- tx_valid/tx_data SHALL stay stable for those 10 cycles;
- an rx byte injected meanwhile SHALL be ignored;
- the handshake SHALL complete in the cycle tx_ready rises.

REQ-030 Reset asserted after the 6th data byte of a frame SHALL produce:
- all outputs at their reset values on the next cycle;
- only addr0 having been written;
- a new full frame completing normally.
